// File: rtl/matrix_op_sequencer_if.sv
// Bus bundle for matrix_op_sequencer: command, operand stream, datapath drive and result stream.
interface matrix_op_sequencer_if #(
   parameter int N = 3,
   parameter int W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [2:0]         cmd_op;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_data;
   logic [2:0]         dp_op;
   logic               dp_start;
   logic [N*N*W-1:0]   dp_a;
   logic [N*N*W-1:0]   dp_b;
   logic               dp_done;
   logic [N*N*W-1:0]   dp_result;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       out_data;
   logic               out_last;

   modport slave (
      input  cmd_valid, cmd_op, in_valid, in_data, dp_done, dp_result, out_ready,
      output cmd_ready, in_ready, dp_op, dp_start, dp_a, dp_b, out_valid, out_data, out_last
   );

   modport master (
      output cmd_valid, cmd_op, in_valid, in_data, dp_done, dp_result, out_ready,
      input  cmd_ready, in_ready, dp_op, dp_start, dp_a, dp_b, out_valid, out_data, out_last
   );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix command: stream operands in, fire the datapath once,
// wait (with timeout) for its result, then stream the result matrix out row-major.
module matrix_op_sequencer #(
   parameter int N       = 3,
   parameter int W       = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   matrix_op_sequencer_if.slave  bus,
   output logic                  busy,
   output logic                  err
);
   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WAIT, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NE*W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]        op_q, op_d;
   logic              err_q, err_d;
   logic              cmd_hs, in_hs, out_hs, last_idx, cnt_end;

   assign cmd_hs   = bus.cmd_valid && (state_q == IDLE);
   assign in_hs    = bus.in_valid && ((state_q == LOAD_A) || (state_q == LOAD_B));
   assign out_hs   = bus.out_ready && (state_q == DRAIN);
   assign last_idx = (idx_q == IW'(NE - 1));
   assign cnt_end  = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_hs) state_d = LOAD_A;
         LOAD_A:  if (in_hs && last_idx) state_d = op_q[2] ? EXEC : LOAD_B;
         LOAD_B:  if (in_hs && last_idx) state_d = EXEC;
         EXEC:    state_d = WAIT;
         // a done on the last allowed cycle takes priority over the abort
         WAIT:    if (bus.dp_done) state_d = DRAIN;
                  else if (cnt_end) state_d = IDLE;
         DRAIN:   if (out_hs && last_idx) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state_q == IDLE);
      bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
      bus.dp_start  = (state_q == EXEC);
      bus.out_valid = (state_q == DRAIN);
      bus.out_last  = (state_q == DRAIN) && last_idx;
      bus.out_data  = '0;
      if (state_q == DRAIN) bus.out_data = res_q[int'(idx_q)*W +: W];
      bus.dp_op     = op_q;
      bus.dp_a      = a_q;
      bus.dp_b      = b_q;
      busy          = (state_q != IDLE);
      err           = err_q;
   end

   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      op_d  = op_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (cmd_hs) begin
            op_d  = bus.cmd_op;
            err_d = 1'b0;
            idx_d = '0;
            a_d   = '0;
            b_d   = '0;
         end
         LOAD_A: if (in_hs) begin
            a_d[int'(idx_q)*W +: W] = bus.in_data;
            idx_d = last_idx ? '0 : idx_q + IW'(1);
         end
         LOAD_B: if (in_hs) begin
            b_d[int'(idx_q)*W +: W] = bus.in_data;
            idx_d = last_idx ? '0 : idx_q + IW'(1);
         end
         EXEC: cnt_d = '0;
         WAIT: begin
            if (bus.dp_done)  res_d = bus.dp_result;
            else if (cnt_end) err_d = 1'b1;
            else              cnt_d = cnt_q + CW'(1);
         end
         DRAIN: if (out_hs) idx_d = last_idx ? '0 : idx_q + IW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         op_q  <= '0;
         err_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         res_q <= res_d;
         op_q  <= op_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomized bench for matrix_op_sequencer with a behavioural datapath responder
// and an element-level reference of the expected result stream.
module tb_matrix_op_sequencer;
   localparam int N = 3, W = 8, TIMEOUT = 15, NE = N * N, PW = NE * W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy, err;
   always #5 clk = ~clk;

   matrix_op_sequencer_if #(.N(N), .W(W)) bus ();
   matrix_op_sequencer #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err)
   );

   int n_chk = 0, n_pass = 0;
   logic [W-1:0] ma [NE];
   logic [W-1:0] mb [NE];
   logic [W-1:0] obs [NE];
   int tr_exp [NE] = '{1, 4, 7, 2, 5, 8, 3, 6, 9};

   int   dp_lat = 1, dp_cd = 0, dp_starts = 0;
   bit   stray = 0;
   logic [PW-1:0] la, lb;
   logic [2:0]    lop;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [PW-1:0] pack(input logic [W-1:0] m [NE]);
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < NE; k++) r[k*W +: W] = m[k];
      return r;
   endfunction

   // datapath behaviour: unary ops transpose, binary op[0] selects subtract vs add
   function automatic logic [PW-1:0] dp_calc(input logic [2:0] op, input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if (op[2])      r[(i*N+j)*W +: W] = a[(j*N+i)*W +: W];
            else if (op[0]) r[(i*N+j)*W +: W] = a[(i*N+j)*W +: W] - b[(i*N+j)*W +: W];
            else            r[(i*N+j)*W +: W] = a[(i*N+j)*W +: W] + b[(i*N+j)*W +: W];
         end
      return r;
   endfunction

   initial begin
      bus.dp_done = 1'b0;
      bus.dp_result = '0;
      forever begin
         @(negedge clk);
         #1;
         bus.dp_done = 1'b0;
         bus.dp_result = {$urandom, $urandom, $urandom};
         if (stray) begin
            bus.dp_done = 1'b1;
            stray = 0;
         end
         if (dp_cd > 0) begin
            dp_cd--;
            if (dp_cd == 0) begin
               bus.dp_done = 1'b1;
               bus.dp_result = dp_calc(lop, la, lb);
            end
         end
         if (bus.dp_start) begin
            dp_starts++;
            dp_cd = dp_lat;
            la = bus.dp_a;
            lb = bus.dp_b;
            lop = bus.dp_op;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {bus.cmd_ready, bus.in_ready, bus.dp_start, bus.out_valid, bus.out_last, busy, err}, 7'b1000000);
      chk({tag, "_dp_op"}, bus.dp_op, 3'b000);
      chk({tag, "_dp_a"}, bus.dp_a, '0);
      chk({tag, "_dp_b"}, bus.dp_b, '0);
      chk({tag, "_out_data"}, bus.out_data, '0);
   endtask

   task automatic load(input bit isb, input bit rnd);
      for (int k = 0; k < NE; k++) begin
         while (rnd && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data = W'($urandom);
            if (!isb && $urandom_range(0, 1) == 1) stray = 1;
            @(negedge clk);
         end
         chk("load_ready", {busy, bus.in_ready, bus.cmd_ready}, 3'b110);
         bus.in_valid = 1'b1;
         bus.in_data = isb ? mb[k] : ma[k];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_data = W'($urandom);
   endtask

   task automatic run_op(input logic [2:0] op, input int lat, input int bp_idx, input int bp_len, input bit rnd);
      logic [W-1:0]  ex [NE];
      logic [PW-1:0] expb;
      int c, j, stall, starts0, cyc;
      bit tmo, rdy;
      tmo = (lat == 0) || (lat > TIMEOUT);
      for (int i = 0; i < N; i++)
         for (int jj = 0; jj < N; jj++) begin
            if (op[2])      ex[i*N+jj] = ma[jj*N+i];
            else if (op[0]) ex[i*N+jj] = W'(ma[i*N+jj] - mb[i*N+jj]);
            else            ex[i*N+jj] = W'(ma[i*N+jj] + mb[i*N+jj]);
         end
      expb = op[2] ? {PW{1'b0}} : pack(mb);
      dp_lat = lat;
      if (rnd) repeat ($urandom_range(0, 2)) begin
         bus.in_valid = 1'b1;
         bus.in_data = W'($urandom);
         @(negedge clk);
         chk("idle_in_ignored", {busy, bus.cmd_ready, bus.in_ready}, 3'b010);
      end
      bus.in_valid = 1'b0;
      chk("cmd_ready", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'($urandom);
      chk("accept", {busy, err, bus.cmd_ready, bus.in_ready}, 4'b1001);
      chk("accept_dp_op", bus.dp_op, op);
      load(1'b0, rnd);
      if (!op[2]) load(1'b1, rnd);
      chk("exec_start", {bus.dp_start, bus.in_ready, busy}, 3'b101);
      chk("exec_dp_a", bus.dp_a, pack(ma));
      chk("exec_dp_b", bus.dp_b, expb);
      chk("exec_dp_op", bus.dp_op, op);
      starts0 = dp_starts;
      @(negedge clk);
      c = 1;
      while (!bus.out_valid && busy && c < TIMEOUT + 5) begin
         @(negedge clk);
         c++;
      end
      if (tmo) begin
         chk("tmo_cycles", c, TIMEOUT + 1);
         chk("tmo_state", {busy, err, bus.out_valid}, 3'b010);
         @(negedge clk);
         chk("post_tmo_idle", {busy, bus.cmd_ready, err, bus.out_valid}, 4'b0110);
      end else begin
         chk("dp_latency", c, lat + 1);
         j = 0;
         stall = 0;
         cyc = 0;
         while (j < NE && cyc < 200) begin
            chk("drain_valid", {bus.out_valid, busy, err}, 3'b110);
            chk("out_data", bus.out_data, ex[j]);
            chk("out_last", bus.out_last, (j == NE - 1));
            chk("drain_dp_op", bus.dp_op, op);
            if (j == bp_idx && stall < bp_len) begin
               rdy = 1'b0;
               stall++;
            end else rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.out_ready = rdy;
            bus.cmd_valid = (j < NE - 1) && rnd && ($urandom_range(0, 1) == 1);
            bus.cmd_op = 3'($urandom);
            if (rdy) begin
               obs[j] = bus.out_data;
               j++;
            end
            @(negedge clk);
            cyc++;
         end
         bus.out_ready = 1'b0;
         bus.cmd_valid = 1'b0;
         chk("drain_count", j, NE);
         chk("post_drain_idle", {bus.out_valid, busy, bus.cmd_ready}, 3'b001);
      end
      chk("one_start", dp_starts, starts0 + 1);
   endtask

   initial begin
      logic [2:0] rop;
      int rlat;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < NE; k++) begin ma[k] = W'(k + 1); mb[k] = '0; end
      run_op(3'b100, 2, -1, 0, 1'b0);
      for (int k = 0; k < NE; k++) chk("transpose_out", obs[k], tr_exp[k]);

      for (int k = 0; k < NE; k++) begin ma[k] = W'(k + 1); mb[k] = W'(k + 10); end
      run_op(3'b000, 3, 4, 3, 1'b0);
      for (int k = 0; k < NE; k++) chk("add_out", obs[k], 2 * k + 11);

      run_op(3'b001, TIMEOUT, -1, 0, 1'b1);
      run_op(3'b100, 0, -1, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("err_sticky", {err, busy}, 2'b10);
      #3 rst = 1'b0;
      #1 chk_reset("reset_err");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(3'b010, TIMEOUT + 1, -1, 0, 1'b1);

      bus.cmd_valid = 1'b1;
      bus.cmd_op = 3'b100;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = W'(k + 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < NE; k++) ma[k] = (k < 5) ? W'(k + 1) : '0;
      chk("mid_load", {busy, bus.in_ready, err}, 3'b110);
      chk("partial_a", bus.dp_a, pack(ma));
      #3 rst = 1'b0;
      #1 chk_reset("reset_mid_load");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NE; k++) begin ma[k] = W'(k + 1); mb[k] = '0; end
      run_op(3'b100, 2, -1, 0, 1'b0);
      for (int k = 0; k < NE; k++) chk("transpose_after_rst", obs[k], tr_exp[k]);

      repeat (25) begin
         rop = 3'($urandom);
         for (int k = 0; k < NE; k++) begin ma[k] = W'($urandom); mb[k] = W'($urandom); end
         rlat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
         run_op(rop, rlat, $urandom_range(0, NE - 1), $urandom_range(0, 4), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
